// File: rtl/uart_lcd.sv
// uart_lcd: 8N1 UART receiver feeding a 16-byte FIFO whose bytes are printed on an HD44780 16x2 LCD.
module uart_lcd #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int BAUD           = 9600,
    parameter int OVERSAMPLE     = 16,
    parameter int FIFO_ADDR_W    = 4,
    parameter int POWERUP_CYCLES = 1_000_000,
    parameter int EN_CYCLES      = 50,
    parameter int CMD_CYCLES     = 100_000
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       rx,
    output logic       rs,
    output logic       rw,
    output logic       enable,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic [7:0] data_lcd
);
    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int BW    = DIV > 1 ? $clog2(DIV) : 1;
    localparam int OW    = $clog2(OVERSAMPLE);
    localparam int DEPTH = 1 << FIFO_ADDR_W;
    localparam int NW    = FIFO_ADDR_W + 1;
    localparam int CW    = $clog2(POWERUP_CYCLES + EN_CYCLES + CMD_CYCLES + 1);

    logic [BW-1:0] tick_cnt;
    logic          tick;
    assign tick = tick_cnt == BW'(DIV - 1);

    always_ff @(posedge clk_50MHz)
        if (reset) tick_cnt <= '0;
        else       tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

    // rx_q is the previous synchronized sample, used for start-edge detection
    logic rx_s1, rx_s, rx_q;
    always_ff @(posedge clk_50MHz)
        if (reset) {rx_s1, rx_s, rx_q} <= 3'b111;
        else       {rx_s1, rx_s, rx_q} <= {rx, rx_s1, rx_s};

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    rx_state_t     rx_state, rx_next;
    logic [OW-1:0] s_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          half, full, rx_done;
    assign half = tick && s_cnt == OW'(OVERSAMPLE / 2 - 1);
    assign full = tick && s_cnt == OW'(OVERSAMPLE - 1);

    always_ff @(posedge clk_50MHz)
        if (reset) rx_state <= R_IDLE;
        else       rx_state <= rx_next;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  rx_next = (rx_q && !rx_s) ? R_START : R_IDLE;
            R_START: rx_next = half ? (rx_s ? R_IDLE : R_DATA) : R_START;
            R_DATA:  rx_next = (full && bit_idx == 3'd7) ? R_STOP : R_DATA;
            R_STOP:  rx_next = full ? R_IDLE : R_STOP;
        endcase
    end

    always_comb rx_done = rx_state == R_STOP && full && rx_s;

    always_ff @(posedge clk_50MHz)
        if (reset) begin
            s_cnt   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            s_cnt   <= (rx_next != rx_state || full) ? '0 : s_cnt + OW'(tick);
            bit_idx <= rx_state != R_DATA ? 3'd0 : bit_idx + 3'(full);
            if (rx_state == R_DATA && full) shift <= {rx_s, shift[7:1]};
        end

    logic [7:0]             mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0]          count, count_n;
    logic                   push, pop, pop_req;
    assign push    = rx_done && count != NW'(DEPTH);
    assign pop     = pop_req && count != '0;
    assign count_n = count + NW'(push) - NW'(pop);

    always_ff @(posedge clk_50MHz)
        if (push) mem[wr_ptr] <= shift;

    always_ff @(posedge clk_50MHz)
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
        end else begin
            wr_ptr     <= wr_ptr + FIFO_ADDR_W'(push);
            rd_ptr     <= rd_ptr + FIFO_ADDR_W'(pop);
            count      <= count_n;
            fifo_full  <= count_n == NW'(DEPTH);
            fifo_empty <= count_n == '0;
        end

    // every command state runs one transfer: SET (bus valid), EN (strobe), WAIT (settle)
    typedef enum logic [2:0] {L_PWR, L_INIT, L_IDLE, L_WRITE, L_LINE2, L_CLR, L_HOME} lcd_state_t;
    typedef enum logic [1:0] {P_SET, P_EN, P_WAIT} phase_t;
    lcd_state_t    state, state_n;
    phase_t        phase, phase_n;
    logic [CW-1:0] cnt;
    logic [2:0]    init_idx;
    logic [4:0]    col;
    logic [7:0]    char_q, init_cmd;
    logic          xfer, en_done, xfer_done;
    assign xfer      = state != L_PWR && state != L_IDLE;
    assign en_done   = phase == P_EN && cnt == CW'(EN_CYCLES - 1);
    assign xfer_done = xfer && phase == P_WAIT && cnt == CW'(CMD_CYCLES - 1);

    always_ff @(posedge clk_50MHz)
        if (reset) begin
            state <= L_PWR;
            phase <= P_SET;
        end else begin
            state <= state_n;
            phase <= phase_n;
        end

    always_comb begin
        state_n = state;
        phase_n = !xfer ? P_SET : phase == P_SET ? P_EN : en_done ? P_WAIT : xfer_done ? P_SET : phase;
        case (state)
            L_PWR:   state_n = cnt == CW'(POWERUP_CYCLES - 1) ? L_INIT : L_PWR;
            L_INIT:  state_n = (xfer_done && init_idx == 3'd4) ? L_IDLE : L_INIT;
            L_IDLE:  state_n = !fifo_empty ? L_WRITE : L_IDLE;
            L_WRITE: state_n = !xfer_done ? L_WRITE : col == 5'd15 ? L_LINE2 : col == 5'd31 ? L_CLR : L_IDLE;
            L_LINE2: state_n = xfer_done ? L_IDLE : L_LINE2;
            L_CLR:   state_n = xfer_done ? L_HOME : L_CLR;
            L_HOME:  state_n = xfer_done ? L_IDLE : L_HOME;
            default: state_n = L_PWR;
        endcase
    end

    always_comb begin
        init_cmd = init_idx == 3'd0 ? 8'h38 : init_idx == 3'd1 ? 8'h0C : init_idx == 3'd2 ? 8'h01 :
                   init_idx == 3'd3 ? 8'h06 : 8'h80;
        enable   = xfer && phase == P_EN;
        rs       = state == L_WRITE;
        rw       = 1'b0;
        pop_req  = state == L_IDLE && !fifo_empty;
        data_lcd = state == L_INIT ? init_cmd : state == L_WRITE ? char_q : state == L_LINE2 ? 8'hC0 :
                   state == L_CLR ? 8'h01 : state == L_HOME ? 8'h80 : 8'h00;
    end

    always_ff @(posedge clk_50MHz)
        if (reset) begin
            cnt      <= '0;
            init_idx <= '0;
            col      <= '0;
            char_q   <= '0;
        end else begin
            cnt      <= (state_n != state || phase_n != phase) ? '0 : cnt + 1'b1;
            init_idx <= init_idx + 3'(state == L_INIT && xfer_done);
            col      <= col + 5'(state == L_WRITE && xfer_done);
            if (pop) char_q <= mem[rd_ptr];
        end
endmodule

// File: tb/tb_uart_lcd.sv
// tb_uart_lcd: directed bench for uart_lcd with the UART and LCD timing scaled down.
module tb_uart_lcd;
    localparam int BAUD = 9600, OVS = 16, CLK_FREQ = BAUD * OVS * 2;
    localparam int BIT = CLK_FREQ / BAUD;
    localparam int PWR = 8000, EN = 5, CMD = 40;

    logic       clk = 1'b0, reset = 1'b1, rx = 1'b1;
    logic       rs, rw, enable, fifo_full, fifo_empty;
    logic [7:0] data_lcd;
    int         passed = 0, total = 0, cyc = 0, rise_c = 0, rel_c = 0;
    logic       en_q = 1'b0;
    logic [8:0] ev_q[$];
    int         wid_q[$], rise_q[$];

    uart_lcd #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OVS), .FIFO_ADDR_W(4),
        .POWERUP_CYCLES(PWR), .EN_CYCLES(EN), .CMD_CYCLES(CMD)
    ) dut (
        .clk_50MHz(clk), .reset(reset), .rx(rx), .rs(rs), .rw(rw), .enable(enable),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .data_lcd(data_lcd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // logs every LCD transfer at the falling edge of enable
    always @(negedge clk) begin
        if (enable === 1'b1 && !en_q) rise_c <= cyc;
        if (enable === 1'b0 && en_q) begin
            ev_q.push_back({rs, data_lcd});
            wid_q.push_back(cyc - rise_c);
            rise_q.push_back(rise_c);
        end
        en_q <= enable === 1'b1;
    end

    task automatic release_reset();
        reset = 1'b0;
        ev_q.delete();
        wid_q.delete();
        rise_q.delete();
        rel_c = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap_bits);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (gap_bits * BIT) @(negedge clk);
    endtask

    task automatic wait_events(input int n, input int limit);
        for (int i = 0; i < limit && ev_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (10) @(negedge clk);
        total += 6;
        if (rs !== 1'b0) $display("FAIL reset_rs: got %b want 0", rs); else passed++;
        if (rw !== 1'b0) $display("FAIL reset_rw: got %b want 0", rw); else passed++;
        if (enable !== 1'b0) $display("FAIL reset_enable: got %b want 0", enable); else passed++;
        if (data_lcd !== 8'h00) $display("FAIL reset_data: got %h want 00", data_lcd); else passed++;
        if (fifo_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", fifo_empty); else passed++;
        if (fifo_full !== 1'b0) $display("FAIL reset_full: got %b want 0", fifo_full); else passed++;
        release_reset();
    endtask

    task automatic test_buffered();
        logic [7:0] chars [3] = '{8'h31, 8'h32, 8'h33};
        for (int i = 0; i < 3; i++) begin
            send_byte(chars[i], 1'b1, 2);
            total++;
            if (fifo_empty !== 1'b0) $display("FAIL buffered_empty[%0d]: got %b want 0", i, fifo_empty);
            else passed++;
        end
    endtask

    task automatic test_init();
        logic [7:0] cmds [5] = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
        wait_events(8, PWR + 2000);
        total++;
        if (ev_q.size() < 8) $display("FAIL init_timeout: got %0d transfers want 8", ev_q.size()); else passed++;
        total++;
        if (rise_q[0] - rel_c < PWR) $display("FAIL powerup_wait: got %0d cycles want >= %0d", rise_q[0] - rel_c, PWR);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            total += 2;
            if (ev_q[i] !== {1'b0, cmds[i]}) $display("FAIL init_cmd[%0d]: got %h want %h", i, ev_q[i], {1'b0, cmds[i]});
            else passed++;
            if (wid_q[i] !== EN) $display("FAIL init_width[%0d]: got %0d want %0d", i, wid_q[i], EN);
            else passed++;
        end
        for (int i = 1; i < 5; i++) begin
            total++;
            if (rise_q[i] - rise_q[i-1] < EN + CMD)
                $display("FAIL init_gap[%0d]: got %0d want >= %0d", i, rise_q[i] - rise_q[i-1], EN + CMD);
            else passed++;
        end
    endtask

    task automatic test_chars();
        logic [7:0] chars [3] = '{8'h31, 8'h32, 8'h33};
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ev_q[5+i] !== {1'b1, chars[i]}) $display("FAIL char[%0d]: got %h want %h", i, ev_q[5+i], {1'b1, chars[i]});
            else passed++;
        end
        repeat (10) @(negedge clk);
        total++;
        if (fifo_empty !== 1'b1) $display("FAIL chars_drained: got %b want 1", fifo_empty); else passed++;
    endtask

    task automatic test_errors();
        ev_q.delete();
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        send_byte(8'h55, 1'b0, 4);
        total += 2;
        if (fifo_empty !== 1'b1) $display("FAIL error_empty: got %b want 1", fifo_empty); else passed++;
        if (ev_q.size() !== 0) $display("FAIL error_writes: got %0d transfers want 0", ev_q.size()); else passed++;
    endtask

    task automatic test_overflow();
        logic [7:0] e;
        reset = 1'b1;
        repeat (10) @(negedge clk);
        release_reset();
        for (int i = 0; i < 17; i++) begin
            send_byte(8'h41 + 8'(i), 1'b1, 1);
            if (i >= 14) begin
                total++;
                if (fifo_full !== (i >= 15)) $display("FAIL overflow_full[%0d]: got %b want %b", i, fifo_full, i >= 15);
                else passed++;
            end
        end
        wait_events(22, 5000);
        total++;
        if (ev_q.size() < 22) $display("FAIL overflow_timeout: got %0d transfers want 22", ev_q.size()); else passed++;
        for (int i = 0; i < 16; i++) begin
            e = 8'h41 + 8'(i);
            total++;
            if (ev_q[5+i] !== {1'b1, e}) $display("FAIL overflow_char[%0d]: got %h want %h", i, ev_q[5+i], {1'b1, e});
            else passed++;
        end
        total += 2;
        if (ev_q[21] !== {1'b0, 8'hC0}) $display("FAIL line2_cmd: got %h want 0c0", ev_q[21]); else passed++;
        if (fifo_empty !== 1'b1) $display("FAIL overflow_drop: got fifo_empty %b want 1", fifo_empty); else passed++;
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        for (int i = 0; i < 16; i++) send_byte(8'h52 + 8'(i), 1'b1, 1);
        wait_events(40, 1000);
        total++;
        if (ev_q.size() !== 40) $display("FAIL wrap_count: got %0d transfers want 40", ev_q.size()); else passed++;
        for (int i = 0; i < 16; i++) begin
            e = 8'h52 + 8'(i);
            total++;
            if (ev_q[22+i] !== {1'b1, e}) $display("FAIL wrap_char[%0d]: got %h want %h", i, ev_q[22+i], {1'b1, e});
            else passed++;
        end
        total += 2;
        if (ev_q[38] !== {1'b0, 8'h01}) $display("FAIL wrap_clear: got %h want 001", ev_q[38]); else passed++;
        if (ev_q[39] !== {1'b0, 8'h80}) $display("FAIL wrap_home: got %h want 080", ev_q[39]); else passed++;
    endtask

    task automatic test_reset_mid();
        fork
            send_byte(8'h62, 1'b1, 1);
        join_none
        for (int i = 0; i < 20 * BIT && enable !== 1'b1; i++) @(negedge clk);
        total++;
        if (enable !== 1'b1) $display("FAIL mid_strobe: got enable %b want 1", enable); else passed++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        total += 4;
        if (enable !== 1'b0) $display("FAIL mid_enable: got %b want 0", enable); else passed++;
        if (rs !== 1'b0) $display("FAIL mid_rs: got %b want 0", rs); else passed++;
        if (data_lcd !== 8'h00) $display("FAIL mid_data: got %h want 00", data_lcd); else passed++;
        if (fifo_empty !== 1'b1) $display("FAIL mid_empty: got %b want 1", fifo_empty); else passed++;
        repeat (10) @(negedge clk);
        release_reset();
        wait_events(1, PWR + 500);
        total += 2;
        if (ev_q[0] !== {1'b0, 8'h38}) $display("FAIL restart_cmd: got %h want 038", ev_q[0]); else passed++;
        if (rise_q[0] - rel_c < PWR) $display("FAIL restart_wait: got %0d cycles want >= %0d", rise_q[0] - rel_c, PWR);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_buffered();
        test_init();
        test_chars();
        test_errors();
        test_overflow();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
